// File: rtl/drv_run_pkg.sv
// rtl/drv_run_pkg.sv - shared types and widths for the driver run-status tracker
package drv_run_pkg;

  localparam int MAX_DRV   = 32;
  localparam int RUN_CNT_W = 32;

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_REQ,
    READY,
    RUN,
    DONE,
    TOUT
  } run_state_e;

endpackage

// File: rtl/drv_mask_reg.sv
// rtl/drv_mask_reg.sv - sticky started/completed driver masks, orphan detect and all-done flag
module drv_mask_reg
  import drv_run_pkg::*;
#(
  parameter int NUM_DRV = 32
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [NUM_DRV-1:0] drv_start,
  input  logic [NUM_DRV-1:0] drv_done,
  output logic [MAX_DRV-1:0] active_drv,
  output logic [MAX_DRV-1:0] passive_drv,
  output logic               orphan_err,
  output logic               complete
);

  logic [MAX_DRV-1:0] start_w;
  logic [MAX_DRV-1:0] done_w;
  logic [MAX_DRV-1:0] orphan_w;

  // Zero-extension keeps bits at and above NUM_DRV permanently clear.
  assign start_w  = MAX_DRV'(drv_start);
  assign done_w   = MAX_DRV'(drv_done);
  assign orphan_w = done_w & ~active_drv & ~start_w;
  assign complete = (active_drv != '0) && (active_drv == passive_drv);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      active_drv  <= '0;
      passive_drv <= '0;
      orphan_err  <= 1'b0;
    end else if (clr) begin
      active_drv  <= '0;
      passive_drv <= '0;
      orphan_err  <= 1'b0;
    end else if (en) begin
      active_drv  <= active_drv | start_w;
      passive_drv <= passive_drv | (done_w & (active_drv | start_w));
      if (|orphan_w) orphan_err <= 1'b1;
    end
  end

endmodule

// File: rtl/drv_run_tracker.sv
// rtl/drv_run_tracker.sv - init sequencing, run FSM and watchdog over up to 32 driver agents
module drv_run_tracker
  import drv_run_pkg::*;
#(
  parameter int NUM_DRV     = 32,
  parameter int INIT_CYCLES = 100,
  parameter int WDOG_LIMIT  = 1000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_DRV-1:0]   drv_start,
  input  logic [NUM_DRV-1:0]   drv_done,
  input  logic                 init_ack,
  input  logic                 clear,
  output logic                 init_req,
  output logic                 init_done,
  output logic [MAX_DRV-1:0]   active_drv,
  output logic [MAX_DRV-1:0]   passive_drv,
  output logic                 run_busy,
  output logic                 run_done,
  output logic                 timeout,
  output logic                 orphan_err,
  output logic [RUN_CNT_W-1:0] run_cycles
);

  logic [1:0]           rst_sync;
  logic                 rst_i;
  run_state_e           state;
  run_state_e           state_nx;
  logic [31:0]          init_cnt;
  logic                 mask_en;
  logic                 clr_en;
  logic                 any_start;
  logic                 complete;
  logic                 cnt_en;
  logic [RUN_CNT_W-1:0] cycles_inc;

  // Assert immediately, release two clocks after reset falls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  assign any_start  = |drv_start;
  assign mask_en    = state inside {READY, RUN, DONE};
  assign clr_en     = clear && (mask_en || (state == TOUT));
  assign cycles_inc = (run_cycles == '1) ? run_cycles : run_cycles + 1'b1;

  drv_mask_reg #(
    .NUM_DRV(NUM_DRV)
  ) u_mask (
    .clock      (clock),
    .rst        (rst_i),
    .en         (mask_en),
    .clr        (clr_en),
    .drv_start  (drv_start),
    .drv_done   (drv_done),
    .active_drv (active_drv),
    .passive_drv(passive_drv),
    .orphan_err (orphan_err),
    .complete   (complete)
  );

  // The launching cycle (READY/DONE with a start) counts as a run cycle.
  always_comb begin
    state_nx = state;
    cnt_en   = 1'b0;
    if (clr_en) begin
      state_nx = READY;
    end else begin
      case (state)
        INIT_WAIT: if ((INIT_CYCLES <= 1) || (init_cnt == 32'(INIT_CYCLES - 1))) state_nx = INIT_REQ;
        INIT_REQ:  if (init_ack) state_nx = READY;
        READY, DONE: begin
          if (any_start) begin
            state_nx = RUN;
            cnt_en   = 1'b1;
          end
        end
        RUN: begin
          cnt_en = 1'b1;
          if (complete && !any_start)                                  state_nx = DONE;
          else if ((WDOG_LIMIT > 0) && (cycles_inc >= 32'(WDOG_LIMIT))) state_nx = TOUT;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      state      <= INIT_WAIT;
      init_cnt   <= '0;
      init_done  <= 1'b0;
      run_cycles <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT_WAIT)            init_cnt  <= init_cnt + 1'b1;
      if ((state == INIT_REQ) && init_ack) init_done <= 1'b1;
      if (clr_en)      run_cycles <= '0;
      else if (cnt_en) run_cycles <= cycles_inc;
    end
  end

  assign init_req = (state == INIT_REQ);
  assign run_busy = (state == RUN);
  assign run_done = (state == DONE);
  assign timeout  = (state == TOUT);

endmodule
